// File: rtl/seg_display.sv
// Six-digit multiplexed common-anode hex display fed by the stopwatch counter.
// Optional leading-zero suppression is enabled with `define SEG_DISPLAY_ZERO_BLANK_EN.
module seg_display #(
  parameter logic [15:0] ScanDiv = 16'd50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] inst,
  input  logic        inst_en,
  input  logic [23:0] counter,
  output logic [7:0]  seg,
  output logic [5:0]  an,
  output logic        frozen
);

  localparam logic [3:0] OP_LDC = 4'h1;
  localparam logic [3:0] OP_FRZ = 4'h2;
  localparam logic [3:0] OP_RUN = 4'h3;
  localparam logic [3:0] OP_BLK = 4'h4;

  typedef enum logic {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } mode_t;

  mode_t       mode;
  mode_t       mode_next;
  logic [23:0] value;
  logic [5:0]  blank;
  logic [15:0] presc;
  logic [2:0]  digit;
  logic [3:0]  opcode;
  logic        ldc_cmd;
  logic        blk_cmd;
  logic [3:0]  nib;
  logic [5:0]  sel;
  logic        hide;
  logic        hi_zero;
  logic [7:0]  seg_next;
  logic [5:0]  an_next;

  function automatic logic [7:0] decode(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      4'hF:    s = 8'h8E;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign opcode  = inst[11:8];
  assign ldc_cmd = inst_en && (opcode == OP_LDC);
  assign blk_cmd = inst_en && (opcode == OP_BLK);

  // Mode next-state from FRZ/RUN commands
  always_comb begin
    mode_next = mode;
    if (inst_en) begin
      case (opcode)
        OP_FRZ:  mode_next = FROZEN;
        OP_RUN:  mode_next = RUN;
        default: mode_next = mode;
      endcase
    end else begin
      mode_next = mode;
    end
  end

  // Mode, value, blank mask and scan position state
  always_ff @(posedge clock) begin
    if (!reset) begin
      mode   <= RUN;
      frozen <= 1'b0;
      value  <= 24'h000000;
      blank  <= 6'h00;
      presc  <= 16'h0000;
      digit  <= 3'd0;
    end else begin
      mode   <= mode_next;
      frozen <= (mode_next == FROZEN);
      if ((mode == RUN) || ldc_cmd) begin
        value <= counter;
      end
      if (blk_cmd) begin
        blank <= inst[5:0];
      end
      if (presc == (ScanDiv - 16'd1)) begin
        presc <= 16'h0000;
        digit <= (digit == 3'd5) ? 3'd0 : (digit + 3'd1);
      end else begin
        presc <= presc + 16'd1;
      end
    end
  end

  // Select the active nibble and anode, and decide whether the slot is hidden
  always_comb begin
    nib     = 4'h0;
    sel     = 6'b000000;
    hi_zero = 1'b0;
    case (digit)
      3'd0: begin nib = value[3:0];   sel = 6'b000001; hi_zero = 1'b0;                   end
      3'd1: begin nib = value[7:4];   sel = 6'b000010; hi_zero = (value[23:4]  == 20'h0); end
      3'd2: begin nib = value[11:8];  sel = 6'b000100; hi_zero = (value[23:8]  == 16'h0); end
      3'd3: begin nib = value[15:12]; sel = 6'b001000; hi_zero = (value[23:12] == 12'h0); end
      3'd4: begin nib = value[19:16]; sel = 6'b010000; hi_zero = (value[23:16] == 8'h0);  end
      3'd5: begin nib = value[23:20]; sel = 6'b100000; hi_zero = (value[23:20] == 4'h0);  end
      default: begin nib = 4'h0; sel = 6'b000000; hi_zero = 1'b0; end
    endcase
`ifdef SEG_DISPLAY_ZERO_BLANK_EN
    hide = ((blank & sel) != 6'h00) || hi_zero;
`else
    hide = ((blank & sel) != 6'h00);
`endif
    if (hide) begin
      an_next  = 6'h3F;
      seg_next = 8'hFF;
    end else begin
      an_next  = ~sel;
      seg_next = decode(nib);
    end
  end

  // Registered display drive
  always_ff @(posedge clock) begin
    if (!reset) begin
      seg <= 8'hFF;
      an  <= 6'h3F;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_seg_display.sv
// Self-checking bench for seg_display: cycle-count based reference model plus
// randomized command/counter stimulus and a few literal checkpoints.
module tb_seg_display;

  localparam int SCAN = 4;
  localparam logic [7:0] SEGTAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clock;
  logic        reset;
  logic [11:0] inst;
  logic        inst_en;
  logic [23:0] counter;
  logic [7:0]  seg;
  logic [5:0]  an;
  logic        frozen;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [23:0] m_value;
  bit          m_frozen;
  logic [5:0]  m_blank;
  int          m_cyc;
  logic [7:0]  exp_seg;
  logic [5:0]  exp_an;
  bit          exp_frozen;
  bit          chk_en = 1'b0;

  seg_display #(.ScanDiv(16'd4)) dut (
    .clock   (clock),
    .reset   (reset),
    .inst    (inst),
    .inst_en (inst_en),
    .counter (counter),
    .seg     (seg),
    .an      (an),
    .frozen  (frozen)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: the output shown after an edge comes from the state before it.
  always @(posedge clock) begin
    int d;
    bit hid;
    logic [3:0] op;
    if (!reset) begin
      m_value = 24'h0; m_frozen = 1'b0; m_blank = 6'h0; m_cyc = 0;
      exp_seg = 8'hFF; exp_an = 6'h3F; exp_frozen = 1'b0;
      chk_en = 1'b1;
    end else begin
      d = (m_cyc / SCAN) % 6;
      hid = m_blank[d];
`ifdef SEG_DISPLAY_ZERO_BLANK_EN
      if (d > 0 && (m_value >> (4 * d)) == 24'h0) hid = 1'b1;
`endif
      if (hid) begin
        exp_an = 6'h3F; exp_seg = 8'hFF;
      end else begin
        exp_an = ~(6'b000001 << d);
        exp_seg = SEGTAB[(m_value >> (4 * d)) & 24'hF];
      end
      op = inst[11:8];
      if (!m_frozen || (inst_en && op == 4'h1)) m_value = counter;
      if (inst_en && op == 4'h4) m_blank = inst[5:0];
      if (inst_en && op == 4'h2) m_frozen = 1'b1;
      if (inst_en && op == 4'h3) m_frozen = 1'b0;
      exp_frozen = m_frozen;
      m_cyc = m_cyc + 1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en) begin
      total = total + 3;
      if (seg !== exp_seg) begin
        bad = bad + 1;
        $display("FAIL model_seg t=%0t got=%h want=%h", $time, seg, exp_seg);
      end
      if (an !== exp_an) begin
        bad = bad + 1;
        $display("FAIL model_an t=%0t got=%h want=%h", $time, an, exp_an);
      end
      if (frozen !== exp_frozen) begin
        bad = bad + 1;
        $display("FAIL model_frozen t=%0t got=%b want=%b", $time, frozen, exp_frozen);
      end
    end
  end

  task automatic pin(input string name, input logic [5:0] want_an,
                     input logic [7:0] want_seg, input logic want_frz);
    total = total + 1;
    if (an !== want_an || seg !== want_seg || frozen !== want_frz) begin
      bad = bad + 1;
      $display("FAIL %s got an=%h seg=%h frz=%b want an=%h seg=%h frz=%b",
               name, an, seg, frozen, want_an, want_seg, want_frz);
    end
  endtask

  task automatic cmd(input logic [3:0] op, input logic [7:0] data, input logic en);
    inst = {op, data};
    inst_en = en;
    @(negedge clock);
    inst_en = 1'b0;
    inst = 12'h000;
  endtask

  initial begin
    logic [7:0] exp_scan [6];
    exp_scan = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    reset = 1'b0; inst = 12'h000; inst_en = 1'b0; counter = 24'h123456;
    @(negedge clock);
    @(negedge clock);
    pin("reset_state", 6'h3F, 8'hFF, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    pin("first_after_release", 6'h3E, 8'hC0, 1'b0);
    @(negedge clock);
    pin("scan_d0", 6'h3E, exp_scan[0], 1'b0);
    for (int i = 1; i < 6; i++) begin
      repeat (SCAN) @(negedge clock);
      pin("scan_slot", ~(6'b000001 << i), exp_scan[i], 1'b0);
    end
    repeat (SCAN) @(negedge clock);
    pin("scan_wrap", 6'h3E, 8'h82, 1'b0);

    cmd(4'h2, 8'h00, 1'b1);
    pin("frz_flag", an, seg, 1'b1);
    counter = 24'h00ABCD;
    repeat (30) @(negedge clock);
    cmd(4'h1, 8'h00, 1'b1);
    repeat (30) @(negedge clock);

    cmd(4'h4, 8'h30, 1'b1);
    repeat (30) @(negedge clock);
    cmd(4'h4, 8'h00, 1'b1);
    repeat (10) @(negedge clock);

    // mid-scan reset while frozen
    while (an !== 6'h37) @(negedge clock);
    reset = 1'b0;
    inst = 12'h300; inst_en = 1'b1;
    @(negedge clock);
    pin("reset_midscan", 6'h3F, 8'hFF, 1'b0);
    inst_en = 1'b0;
    reset = 1'b1;
    counter = 24'h000007;
    repeat (3) @(negedge clock);
    pin("live_after_reset", 6'h3E, 8'hF8, 1'b0);

    cmd(4'h2, 8'h00, 1'b1);
    cmd(4'h9, 8'h3F, 1'b1);
    cmd(4'h3, 8'h00, 1'b0);
    counter = 24'h654321;
    repeat (30) @(negedge clock);
    cmd(4'h3, 8'h00, 1'b1);

    counter = 24'h000050;
    repeat (30) @(negedge clock);
    counter = 24'h000000;
    repeat (30) @(negedge clock);

    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 299) != 0);
      inst_en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) inst[11:8] = 4'($urandom_range(0, 15));
      else inst[11:8] = 4'($urandom_range(0, 4));
      inst[7:0] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      case ($urandom_range(0, 5))
        0: counter = 24'($urandom);
        1: counter = 24'($urandom_range(0, 255));
        2: counter = 24'h000000;
        default: counter = counter;
      endcase
      @(negedge clock);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_display.md
Name: seg_display

Overview:
- Downstream consumer of the stopwatch counter (Swc `counter[23:0]`). Shows the value as six hex digits on a multiplexed, common-anode 7-segment display.
- Controlled by the sequencer through the same 12-bit `inst`/`inst_en` command port as Alu and Swc: `inst[11:8]` is the opcode, `inst[7:0]` the data. It is driven from `seq_oreg` with its own `seq_oreg_wen` bit.

Parameters:
- ScanDiv, 16'd50000, clock cycles per digit slot in the scan (legal range 2..65535).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- inst  input  12  command: [11:8] opcode, [7:0] data
- inst_en  input  1  command strobe; `inst` is sampled only when 1
- counter  input  24  value to display (Swc counter)
- seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}, registered
- an  output  6  active-low digit enables, an[0] = least significant nibble, registered
- frozen  output  1  1 = display value held (FRZ mode), registered

Behaviour:
- Opcodes, acted on only when inst_en=1:
  - 4'h0 NOP.
  - 4'h1 LDC: value <= counter on that edge.
  - 4'h2 FRZ: mode <= FROZEN.
  - 4'h3 RUN: mode <= RUN.
  - 4'h4 BLK: blank <= inst[5:0]; inst[7:6] ignored.
  - Any other opcode: no state change.
- Mode RUN: value <= counter every cycle. Mode FROZEN: value changes only on LDC.
- LDC in RUN mode is harmless; value loads counter as usual.
- Mode register: 2 states, RUN and FROZEN; reset to RUN. Output frozen = (mode==FROZEN), updated on the same edge as the FRZ/RUN command.
- Prescaler, 16 bits:
  - Counts 0..ScanDiv-1, then wraps to 0.
  - On the wrap edge, the 3-bit digit index advances 0,1,2,3,4,5,0,... Index 5 wraps to 0; it never reaches 6 or 7.
- Output register, loaded every cycle from the current digit index d:
  - an <= ~(6'b1 << d), or 6'h3F if blank[d]=1.
  - seg <= decode(value[4d+3:4d]), or 8'hFF if blank[d]=1.
  - Latency: an and seg reflect a new digit index, value or blank one cycle after it changes.
- Decode table, dp always off (bit7=1):
  - 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8
  - 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E
- Reset (reset=0 at a rising edge), regardless of any in-flight activity:
  - value=0, mode=RUN, blank=0, prescaler=0, digit=0.
  - seg=8'hFF, an=6'h3F, frozen=0.
  - inst_en is ignored while reset=0.
  - First cycle after release: an=6'h3E, seg=8'hC0.
- Simultaneous events:
  - LDC and a counter change in the same cycle: the value present on `counter` at that edge is captured.
  - BLK on the same edge as a digit advance: the new mask applies to the output loaded on the following edge.

Optional Feature:
- Macro SEG_DISPLAY_ZERO_BLANK_EN.
- Defined: leading-zero suppression.
  - Digit d is additionally blanked (an bit high, seg=FF) when value[23:4d] is all zero and d>0.
  - Digit 0 is always shown unless blank[0]=1.
  - Combined with blank[] by OR.
- Not defined: no suppression; all six digits show unless masked.

Test Plan:
- ScanDiv=4, reset low 2 cycles, then release with counter=24'h123456 → after reset release, scan an=3E/3D/3B/37/2F/1F, each held 4 cycles, with seg=82,92,99,B0,A4,F9; the cycle wraps back to an=3E.
- Command FRZ, then change counter to 24'h00ABCD → frozen=1, display still 123456. Command LDC → digits 0..5 show seg=A1,C6,83,88,C0,C0.
- Command BLK data 8'h30 → an[5:4] stay high through the full scan, seg=FF in those slots; other digits unchanged. Command BLK data 8'h00 restores them.
- Pulse reset low mid-scan (digit 3, frozen=1) → next cycle seg=FF, an=3F, frozen=0. After release, digit 0 shows live counter.
- Opcode 4'h9 with inst_en=1, and RUN with inst_en=0 → no change to mode, value or blank.
- With SEG_DISPLAY_ZERO_BLANK_EN defined, counter=24'h000050 in RUN → only an[0] and an[1] ever go low, showing C0 and 92. With counter=0, only digit 0 is shown, with seg=C0.
